// File: rtl/canakari_access_arbiter.sv
// Round-robin arbiter sharing one CANakari register-access port among N_REQ requesters.
// Each grant runs LATCH -> STROBE -> WAIT(ACC_LAT) -> DONE and returns to IDLE.
module canakari_access_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16,
  parameter int ACC_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          we_i,
  input  logic [N_REQ*ADDR_W-1:0]   addr_i,
  input  logic [N_REQ*DATA_W-1:0]   wdata_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic [N_REQ-1:0]          ack_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      buf_en_o,
  output logic [ADDR_W-1:0]         buf_addr_o,
  output logic                      can_re_o,
  output logic                      can_we_o,
  output logic [DATA_W-1:0]         can_wdata_o,
  input  logic [DATA_W-1:0]         can_rdata_i,
  output logic                      busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_STROBE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, owner_q, win, ptr_next;
  logic                win_found;
  logic [PTR_W:0]      scan_idx;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [N_REQ-1:0]    grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wait_done;

  logic [ADDR_W-1:0]   addr_arr  [N_REQ];
  logic [DATA_W-1:0]   wdata_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan upward from the pointer, wrapping; the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win       = ptr_q;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan_idx >= (PTR_W+1)'(N_REQ)) begin
        scan_idx = scan_idx - (PTR_W+1)'(N_REQ);
      end
      if (!win_found && req_i[scan_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win       = scan_idx[PTR_W-1:0];
      end
    end
  end

  assign wait_done = (state_q == S_WAIT) && (cnt_q == CNT_W'(ACC_LAT - 1));
  assign ptr_next  = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_o   = (state_q != S_IDLE);
    buf_en_o = 1'b0;
    can_re_o = 1'b0;
    can_we_o = 1'b0;
    ack_o    = '0;
    case (state_q)
      S_IDLE:   if (win_found) state_d = S_LATCH;
      S_LATCH: begin
        buf_en_o = 1'b1;
        state_d  = S_STROBE;
      end
      S_STROBE: begin
        can_re_o = ~we_q;
        can_we_o = we_q;
        state_d  = S_WAIT;
      end
      S_WAIT:   if (wait_done) state_d = S_DONE;
      S_DONE: begin
        ack_o   = grant_q;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Request inputs are captured once at grant time; later changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            owner_q <= win;
            we_q    <= we_i[win];
            addr_q  <= addr_arr[win];
            wdata_q <= wdata_arr[win];
            grant_q <= N_REQ'(1) << win;
          end
        end
        S_STROBE: cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (wait_done && !we_q) rdata_q <= can_rdata_i;
        end
        S_DONE: begin
          ptr_q   <= ptr_next;
          grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign rdata_o     = rdata_q;
  assign buf_addr_o  = addr_q;
  assign can_wdata_o = wdata_q;

endmodule
